// File: rtl/sumator_pkg.sv
// Shared types and helpers for the serial adder/subtractor.
// Imported by the chunk slice and the top level.
package sumator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sumator_if.sv
// Operand and result handshake bundle of the serial adder.
// master = producer/consumer side, slave = the adder.
interface sumator_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid,
        output a,
        output b,
        output sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  carry,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output carry,
        output overflow
    );

endinterface

// File: rtl/sumator_chunk.sv
// Combinational CHUNK-bit adder slice, reused once per chunk.
// cmsb is the carry into the slice MSB, needed for overflow.
module sumator_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] t;

    assign t    = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    assign s    = t[CHUNK-1:0];
    assign cout = t[CHUNK];
    // sum bit = x ^ y ^ carry-in, so the carry-in is recovered by xor
    assign cmsb = t[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];

endmodule

// File: rtl/sumator_serial.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock.
// Operands are captured once; result is held until consumed.
module sumator_serial
    import sumator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic      clk,
    input logic      rst,
    sumator_if.slave bus
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = idx_w(N);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic             carry_q;
    logic             ovf_q;
    logic [IW-1:0]    idx_q;

    logic in_ready;
    logic out_valid;
    logic load;
    logic step;
    logic last;

    logic [CHUNK-1:0] x;
    logic [CHUNK-1:0] y;
    logic [CHUNK-1:0] s;
    logic             cout;
    logic             cmsb;

    assign last = (idx_q == IW'(N - 1));

    always_comb begin
        x = '0;
        y = '0;
        for (int j = 0; j < N; j++) begin
            if (idx_q == IW'(j)) begin
                x = a_q[j*CHUNK +: CHUNK];
                y = b_q[j*CHUNK +: CHUNK];
            end
        end
    end

    sumator_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .x   (x),
        .y   (y),
        .cin (c_q),
        .s   (s),
        .cout(cout),
        .cmsb(cmsb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (load) begin
            // subtract as a + ~b + 1: the +1 enters as chunk-0 carry
            a_q   <= bus.a;
            b_q   <= (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
            c_q   <= (bus.sub == MODE_SUB);
            idx_q <= '0;
        end else if (step) begin
            for (int j = 0; j < N; j++) begin
                if (idx_q == IW'(j)) begin
                    sum_q[j*CHUNK +: CHUNK] <= s;
                end
            end
            c_q <= cout;
            if (last) begin
                idx_q   <= '0;
                carry_q <= cout;
                ovf_q   <= cout ^ cmsb;
            end else begin
                idx_q <= idx_q + IW'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_sumator_serial.sv
// Directed and random checks of sumator_serial at 16/4 and 4/4,
// against an integer-arithmetic reference model.
module tb_sumator_serial;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    sumator_if #(.WIDTH(16)) i16 ();
    sumator_if #(.WIDTH(4))  i4 ();

    sumator_serial #(
        .WIDTH(16),
        .CHUNK(4)
    ) dut16 (
        .clk(clk),
        .rst(rst),
        .bus(i16)
    );

    sumator_serial #(
        .WIDTH(4),
        .CHUNK(4)
    ) dut4 (
        .clk(clk),
        .rst(rst),
        .bus(i4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // plain integer arithmetic: unsigned for sum/carry, signed for overflow
    function automatic void model(input int w, input logic [15:0] ta,
                                  input logic [15:0] tb_, input logic ts,
                                  output logic [15:0] es, output logic ec,
                                  output logic eo);
        longint m;
        longint ua;
        longint ub;
        longint r;
        longint sa;
        longint sb;
        longint sr;
        m  = longint'(1) << w;
        ua = longint'(ta) % m;
        ub = longint'(tb_) % m;
        r  = ts ? ua - ub : ua + ub;
        es = 16'(((r % m) + m) % m);
        ec = ts ? (ua >= ub) : (r >= m);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        sr = ts ? sa - sb : sa + sb;
        eo = (sr < -(m / 2)) || (sr >= m / 2);
    endfunction

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb_,
                         input logic ts, input int hold);
        logic [15:0] es;
        logic        ec;
        logic        eo;
        int          n;
        model(16, ta, tb_, ts, es, ec, eo);
        n = 0;
        while (!i16.in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("w16_idle_ready", 32'(i16.in_ready), 32'd1);
        i16.in_valid  = 1'b1;
        i16.a         = ta;
        i16.b         = tb_;
        i16.sub       = ts;
        i16.out_ready = (hold == 0);
        tick();
        i16.in_valid = 1'b0;
        n = 0;
        while (!i16.out_valid && n < 50) begin
            i16.a   = 16'($urandom);
            i16.b   = 16'($urandom);
            i16.sub = 1'($urandom);
            tick();
            n++;
        end
        chk("w16_latency", 32'(n), 32'd4);
        chk("w16_sum", 32'(i16.sum), 32'(es));
        chk("w16_carry", 32'(i16.carry), 32'(ec));
        chk("w16_overflow", 32'(i16.overflow), 32'(eo));
        for (int h = 0; h < hold; h++) begin
            i16.in_valid = 1'b1;
            tick();
            chk("w16_hold_valid", 32'(i16.out_valid), 32'd1);
            chk("w16_hold_ready", 32'(i16.in_ready), 32'd0);
            chk("w16_hold_sum", 32'(i16.sum), 32'(es));
            chk("w16_hold_cv", 32'({i16.carry, i16.overflow}),
                32'({ec, eo}));
        end
        i16.out_ready = 1'b1;
        tick();
        chk("w16_hs_valid", 32'(i16.out_valid), 32'd0);
        chk("w16_hs_ready", 32'(i16.in_ready), 32'd1);
        i16.out_ready = 1'b0;
        i16.in_valid  = 1'b0;
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_,
                        input logic ts);
        logic [15:0] es;
        logic        ec;
        logic        eo;
        int          n;
        model(4, 16'(ta), 16'(tb_), ts, es, ec, eo);
        chk("w4_idle_ready", 32'(i4.in_ready), 32'd1);
        i4.in_valid  = 1'b1;
        i4.a         = ta;
        i4.b         = tb_;
        i4.sub       = ts;
        i4.out_ready = 1'b1;
        tick();
        i4.in_valid = 1'b0;
        n = 0;
        while (!i4.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("w4_latency", 32'(n), 32'd1);
        chk("w4_sum", 32'(i4.sum), 32'(es[3:0]));
        chk("w4_cv", 32'({i4.carry, i4.overflow}), 32'({ec, eo}));
        tick();
        chk("w4_hs_ready", 32'(i4.in_ready), 32'd1);
        i4.out_ready = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        {i16.in_valid, i16.sub, i16.out_ready} = '0;
        {i16.a, i16.b} = '0;
        {i4.in_valid, i4.sub, i4.out_ready} = '0;
        {i4.a, i4.b} = '0;
        tick();
        tick();
        chk("rst_in_ready", 32'(i16.in_ready), 32'd1);
        chk("rst_out_valid", 32'(i16.out_valid), 32'd0);
        chk("rst_sum", 32'(i16.sum), 32'd0);
        chk("rst_cv", 32'({i16.carry, i16.overflow}), 32'd0);
        chk("rst4_ready", 32'(i4.in_ready), 32'd1);
        chk("rst4_valid", 32'(i4.out_valid), 32'd0);
        rst = 1'b0;
        tick();

        run16(16'hFFFF, 16'h0001, 1'b0, 0);
        run16(16'h7FFF, 16'h0001, 1'b0, 0);
        run16(16'h8000, 16'h0001, 1'b1, 0);
        run16(16'h0005, 16'h0007, 1'b1, 0);
        run16(16'h1357, 16'h2468, 1'b0, 5);

        i16.in_valid  = 1'b1;
        i16.a         = 16'hAAAA;
        i16.b         = 16'h5555;
        i16.sub       = 1'b0;
        i16.out_ready = 1'b1;
        tick();
        i16.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ready", 32'(i16.in_ready), 32'd1);
        chk("midrst_valid", 32'(i16.out_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("midrst_quiet", 32'(i16.out_valid), 32'd0);
        end
        i16.out_ready = 1'b0;
        run16(16'h1234, 16'h1111, 1'b0, 0);
        chk("post_rst_sum", 32'(i16.sum), 32'h2345);

        run4(4'b1111, 4'b1111, 1'b0);
        run4(4'b0111, 4'b0001, 1'b0);
        run4(4'b1000, 4'b0001, 1'b1);

        for (int r = 0; r < 20; r++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)));
        end
        for (int r = 0; r < 12; r++) begin
            run4(4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
